reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- Architectural general-purpose register file for the single-cycle CPU.
- Sits directly upstream of the ALU and supplies its two 32-bit operands from rs/rt.
- Accepts the writeback value (ALU result or memory load data) on a single write port.
- Provides a third read port for board-level debug display.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports.
- ADDR_WIDTH, 5, register address width; register count is 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- ra1  input  ADDR_WIDTH  read address, port 1 (rs); drives ALU operand a.
- ra2  input  ADDR_WIDTH  read address, port 2 (rt); drives ALU operand b / store data.
- rd1  output  DATA_WIDTH  read data, port 1.
- rd2  output  DATA_WIDTH  read data, port 2.
- we  input  1  write enable from control unit (RegWrite).
- wa  input  ADDR_WIDTH  write address (rd or rt, selected upstream).
- wd  input  DATA_WIDTH  write data from writeback mux.
- dbg_addr  input  ADDR_WIDTH  debug read address (board switches).
- dbg_data  output  DATA_WIDTH  debug read data (seven-segment / LED driver).

Behaviour:
- Storage: 2**ADDR_WIDTH registers of DATA_WIDTH bits; register 0 is hardwired to zero.
- Reads: rd1, rd2 and dbg_data are purely combinational from current storage, with zero latency, so the single-cycle datapath (regfile -> ALU -> writeback) closes within one clock.
- Address 0 on any read port returns 0 regardless of history.
- Write:
  - On rising clk with rst=0 and we=1 and wa!=0, register[wa] <= wd.
  - Visible on reads from the following cycle.
  - we=1 with wa=0 is accepted and discarded; no state change.
- Reset:
  - On rising clk with rst=1, every register is cleared to 0 in that single cycle.
  - rst has priority over a simultaneous write; the write is dropped.
  - Reset asserted mid-program discards all contents; no partial-clear states.
- Outputs after reset: rd1=rd2=dbg_data=0 for any address until a write occurs.
- Simultaneous read and write of the same address in one cycle:
  - Default: reads return the old stored value.
  - See the optional feature for the alternative.
- Both read ports may address the same register; both return identical data.
- No X propagation: all registers have a defined reset value; read addresses are full-range, so no out-of-range case exists.
- Implementation: flip-flop array (not block RAM) so that combinational reads are legal on the target FPGA.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - rd1/rd2/dbg_data return wd combinationally when we=1, rst=0, wa!=0 and the read address equals wa (write-through forwarding).
  - Used when the register write is later moved to the falling edge or a pipeline is introduced.
- Undefined: no forwarding; same-cycle reads return the pre-write stored value.
- Neither configuration affects the register-0 or reset-priority rules. Under bypass with rst=1, no forwarding occurs.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, pulse rst one cycle -> rd1 with ra1=5 reads 0x00000000 next cycle; dbg_data with dbg_addr=5 reads 0.
- Write/readback: we=1, wa=3, wd=0x12345678 for one edge, then ra1=3, ra2=3 -> rd1=rd2=0x12345678; r4 unchanged at 0.
- Register zero: we=1, wa=0, wd=0xFFFFFFFF -> ra1=0 reads 0x00000000 on the same and following cycles.
- Reset priority: rst=1 and we=1, wa=7, wd=0xA5A5A5A5 on the same edge -> r7 reads 0 afterwards.
- Same-cycle read/write: r9=0x11111111, then we=1, wa=9, wd=0x22222222 with ra1=9:
  - Before the edge, rd1 reads 0x11111111 without the macro and 0x22222222 with REGFILE_BYPASS_EN.
  - After the edge, both configurations read 0x22222222.
- Dual-port independence: r1=0x00000005, r2=0x00000003, ra1=1, ra2=2 -> rd1=5, rd2=3. Driving these into the ALU with subtract selected yields 2 and zf=0.

Source files
------------

// File: rtl/reg_file.sv
// Architectural register file: three combinational read ports, one synchronous write port, r0 hardwired to zero.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] ra1,
    input  logic [ADDR_WIDTH-1:0] ra2,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wa,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  write_ok;

    // A write to r0 is accepted on the interface but never stored.
    assign write_ok = we && !rst && (wa != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[wa] <= wd;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] value;
        value = '0;
        if (addr != '0) begin
`ifdef REGFILE_BYPASS_EN
            if (write_ok && (addr == wa)) begin
                value = wd;
            end else begin
                value = regs[addr];
            end
`else
            value = regs[addr];
`endif
        end
        return value;
    endfunction

    assign rd1      = read_port(ra1);
    assign rd2      = read_port(ra2);
    assign dbg_data = read_port(dbg_addr);

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic against an array model.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    logic [31:0] model [32];
    int          n_vec;
    int          n_fail;

    reg_file dut (
        .clk      (clk),
        .rst      (rst),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Expected read value for the current inputs, from the architectural rules.
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (we && !rst && wa == a) return wd;
`endif
        return model[a];
    endfunction

    // Check all read ports before the edge, clock once, update the model, return at negedge.
    task automatic cycle();
        #1;
        check("rd1", rd1, exp_read(ra1));
        check("rd2", rd2, exp_read(ra2));
        check("dbg", dbg_data, exp_read(dbg_addr));
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (we && wa != 5'd0) begin
            model[wa] = wd;
        end
        @(negedge clk);
    endtask

    task automatic drive_write(input logic [4:0] a, input logic [31:0] d);
        rst = 1'b0; we = 1'b1; wa = a; wd = d;
        cycle();
        we = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_fail = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0;
        ra1 = '0; ra2 = '0; dbg_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state across a sweep of addresses.
        for (int i = 0; i < 32; i += 4) begin
            ra1 = 5'(i); ra2 = 5'(i + 1); dbg_addr = 5'(i + 2);
            #1;
            check("reset_rd1", rd1, 32'd0);
            check("reset_rd2", rd2, 32'd0);
            check("reset_dbg", dbg_data, 32'd0);
        end

        // Reset clears a written register.
        drive_write(5'd5, 32'hDEADBEEF);
        ra1 = 5'd5; dbg_addr = 5'd5;
        #1 check("r5_written", rd1, 32'hDEADBEEF);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        check("r5_after_rst", rd1, 32'd0);
        check("dbg_after_rst", dbg_data, 32'd0);

        // Write and readback on both ports; neighbour untouched.
        drive_write(5'd3, 32'h12345678);
        ra1 = 5'd3; ra2 = 5'd3; dbg_addr = 5'd4;
        #1;
        check("wr_rd1", rd1, 32'h12345678);
        check("wr_rd2", rd2, 32'h12345678);
        check("r4_untouched", dbg_data, 32'd0);

        // Writes to r0 are discarded.
        ra1 = 5'd0;
        rst = 1'b0; we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
        #1 check("r0_same", rd1, 32'd0);
        cycle();
        we = 1'b0;
        #1 check("r0_next", rd1, 32'd0);

        // Reset beats a simultaneous write.
        ra1 = 5'd7;
        rst = 1'b1; we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5;
        #1 check("rst_no_fwd", rd1, 32'd0);
        cycle();
        rst = 1'b0; we = 1'b0;
        #1 check("rst_priority", rd1, 32'd0);

        // Same-cycle read and write.
        drive_write(5'd9, 32'h11111111);
        ra1 = 5'd9;
        we = 1'b1; wa = 5'd9; wd = 32'h22222222;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("rw_before", rd1, 32'h22222222);
`else
        check("rw_before", rd1, 32'h11111111);
`endif
        cycle();
        we = 1'b0;
        #1 check("rw_after", rd1, 32'h22222222);

        // Dual-port independence feeding a subtract.
        drive_write(5'd1, 32'd5);
        drive_write(5'd2, 32'd3);
        ra1 = 5'd1; ra2 = 5'd2;
        #1;
        check("dual_rd1", rd1, 32'd5);
        check("dual_rd2", rd2, 32'd3);
        check("alu_sub", rd1 - rd2, 32'd2);
        check("alu_zf", {31'd0, (rd1 - rd2) == 32'd0}, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(29, 0) == 0);
            we  = ($urandom_range(9, 0) < 7);
            wa  = 5'($urandom_range(31, 0));
            wd  = $urandom();
            ra1 = ($urandom_range(3, 0) == 0) ? wa : 5'($urandom_range(31, 0));
            ra2 = ($urandom_range(3, 0) == 0) ? ra1 : 5'($urandom_range(31, 0));
            dbg_addr = ($urandom_range(3, 0) == 0) ? wa : 5'($urandom_range(31, 0));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
